loader_ctrl_wb: RTL and testbench
=================================

// Module: loader_ctrl_wb
// PURPOSE
//  UART-triggered boot/program-load controller and Wishbone slave; successor to the single-sequence loader.
//  Watches received UART bytes for a parametrised preamble/trigger sequence and pulses the core reset.
//  Tracks the incoming program stream with a byte counter and an inter-byte timeout, then pulses reset again.
//  Exposes reset cause, status and control registers to firmware.
// PARAMETERS
//  PREAMBLE_BYTE    8'h2D      first byte of the arm sequence ('-')
//  FILLER_BYTE      8'h5F      byte tolerated while armed ('_')
//  TRIGGER_BYTE     8'h70      byte that fires the load reset ('p')
//  RST_PULSE_CYCLES 1          reset_o low width in cycles; must be >= 1
//  TIMEOUT_CYCLES   200000000  idle cycles after the last byte that end a load; must be >= 2
// PORTS
//  wb_clk_i      in   1   system clock; all logic on the rising edge
//  wb_rst_i      in   1   asynchronous, active-low reset
//  wb_cyc_i      in   1   Wishbone cycle
//  wb_stb_i      in   1   Wishbone strobe
//  wb_we_i       in   1   write enable
//  wb_adr_i      in   32  byte address; only [3:2] is decoded
//  wb_dat_i      in   32  write data
//  wb_sel_i      in   4   byte selects; ignored, all accesses are full-word
//  wb_stall_o    out  1   tied 0
//  wb_ack_o      out  1   access acknowledge
//  wb_err_o      out  1   access error
//  wb_dat_o      out  32  read data
//  uart_rx_irq   in   1   one-cycle strobe: uart_rx_byte is valid
//  uart_rx_byte  in   8   received byte
//  reset_o       out  1   active-low core reset pulse
//  state_o       out  3   current FSM state, for LEDs and debug
// BEHAVIOUR
//  Reset values: reset_o=1, ack/err/dat_o=0, state=IDLE, CAUSE=0, CTRL.EN=1, counters=0.
//  Bus timing: stb&cyc sampled on edge N; exactly one of ack or err is high during cycle N+1.
//   dat_o is registered and valid with ack.
//  Register map (wb_adr_i[3:2]):
//   0 CAUSE  [1:0]=0 none, 1 trigger, 2 load done, 3 sw reset.
//            Any write clears it to 0; a cause event in the same cycle wins over the clear.
//   1 STATUS RO [2:0]=state, [31:8]=byte count. Writes are acked and ignored.
//   2 CTRL   [0]=EN, R/W. [1]=SWRST, write-only, always reads 0.
//   3 unmapped: err=1, ack=0, no side effect.
//  FSM (state_o encoding in parentheses):
//   IDLE(0):  irq & byte==PREAMBLE & EN -> ARMED.
//   ARMED(1): irq & byte==TRIGGER -> FIRE, CAUSE<=1.
//             irq & byte in {FILLER, PREAMBLE} -> stay.
//             any other irq -> IDLE. EN has no effect once armed.
//   FIRE(2):  reset_o=0 for RST_PULSE_CYCLES cycles, starting the cycle after the trigger irq.
//             Byte count <=0 on entry. Then -> LOAD.
//   LOAD(3):  waits indefinitely; irq -> RECV, count<=1, timer<=0.
//   RECV(4):  irq -> count+1 (saturates at 24'hFFFFFF), timer<=0. Otherwise timer+1.
//             timer==TIMEOUT_CYCLES-1 with no irq -> DONE, CAUSE<=2.
//             irq on the terminal cycle: the irq wins and the block stays in RECV.
//   DONE(5):  reset_o=0 for RST_PULSE_CYCLES cycles, then -> IDLE. Byte count is retained.
//   Codes 6-7 are illegal and go to IDLE on the next cycle.
//  irq during FIRE or DONE is ignored.
//  The pulse counter clears on every state entry.
//  Asynchronous reset mid-pulse: reset_o returns to 1 immediately.
//  reset_o is registered and glitch-free; this block does not receive reset_o.
// CONFIGURATION
//  LOADER_SW_RESET_EN defined:
//   A write with CTRL[1]=1 while in IDLE or ARMED -> DONE with CAUSE<=3, producing the same pulse.
//   The same write is ignored in other states. CTRL[0] is still written by that access.
//  LOADER_SW_RESET_EN undefined: CTRL[1] is ignored and no software reset logic is built.
// TESTING  (bench params: RST_PULSE_CYCLES=4, TIMEOUT_CYCLES=100)
//  1. Release reset.
//     -> reset_o=1, state_o=0. CAUSE reads 0. CTRL reads 1. Read of 0xC gives err=1, ack=0.
//  2. Bytes 2D,5F,2D,70.
//     -> reset_o low exactly 4 cycles, starting the cycle after the 70 irq.
//     -> CAUSE=1, then state_o=3.
//  3. From LOAD, 10 bytes spaced 50 cycles, then silence.
//     -> STATUS count=10. 100 cycles after the last irq, reset_o is low 4 cycles.
//     -> CAUSE=2, then state_o=0.
//     Repeat with an irq on the terminal cycle -> stays in RECV, count=11.
//  4. Bytes 2D,41 -> IDLE, no pulse, CAUSE unchanged.
//     CTRL<=0, then 2D,70 -> stays IDLE, no pulse.
//     Write CAUSE -> reads 0.
//  5. Assert wb_rst_i=0 during the FIRE pulse.
//     -> reset_o=1 immediately, state_o=0, CAUSE=0.
//  6. CTRL<=3 in IDLE.
//     With macro: 4-cycle pulse, CAUSE=3.
//     Without macro: no pulse, CTRL reads 1.

Source files
------------

// File: rtl/loader_ctrl_wb.sv
// loader_ctrl_wb: UART-triggered boot/program-load controller with a Wishbone slave.
// The controller watches received bytes for a preamble/filler/trigger sequence and
// pulses the core reset. It then counts the incoming program bytes and ends the load
// on an inter-byte timeout with a second reset pulse.
// Firmware can read the reset cause, the current state and the byte count, and it
// controls the enable bit.
// Optional feature: define LOADER_SW_RESET_EN to build the software reset (CTRL[1]).

module loader_ctrl_wb #(
  parameter logic [7:0]  PREAMBLE_BYTE    = 8'h2D,
  parameter logic [7:0]  FILLER_BYTE      = 8'h5F,
  parameter logic [7:0]  TRIGGER_BYTE     = 8'h70,
  parameter int unsigned RST_PULSE_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYCLES   = 200000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  input  logic        uart_rx_irq,
  input  logic [7:0]  uart_rx_byte,
  output logic        reset_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FIRE  = 3'd2,
    S_LOAD  = 3'd3,
    S_RECV  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ADR_CAUSE  = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_NONE   = 2'd3;

  localparam logic [1:0] CAUSE_TRIGGER = 2'd1;
  localparam logic [1:0] CAUSE_DONE    = 2'd2;
  localparam logic [1:0] CAUSE_SWRST   = 2'd3;

  localparam logic [31:0] PULSE_LAST = 32'(RST_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] COUNT_MAX  = 24'hFFFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pulse_cnt;
  logic [31:0] r_timer;
  logic [23:0] r_byte_cnt;
  logic [1:0]  r_cause;
  logic        r_en;
  logic        r_reset_n;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;

  logic        w_bus_req;
  logic [1:0]  w_addr;
  logic        w_wr_cause;
  logic        w_wr_ctrl;
  logic        w_rd;
  logic        w_pulse_last;
  logic        w_cause_evt;
  logic [1:0]  w_cause_val;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_bus_req  = wb_cyc_i & wb_stb_i;
  assign w_addr     = wb_adr_i[3:2];
  assign w_wr_cause = w_bus_req & wb_we_i & (w_addr == ADR_CAUSE);
  assign w_wr_ctrl  = w_bus_req & wb_we_i & (w_addr == ADR_CTRL);
  assign w_rd       = w_bus_req & ~wb_we_i & (w_addr != ADR_NONE);

  assign w_pulse_last = (r_pulse_cnt == PULSE_LAST);

`ifdef LOADER_SW_RESET_EN
  logic w_sw_rst;

  assign w_sw_rst = w_wr_ctrl & wb_dat_i[1] &
                    ((r_state == S_IDLE) | (r_state == S_ARMED));
  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:2]};
`else
  assign w_unused = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:1]};
`endif

  // Next-state decode plus the cause event that accompanies a transition
  always_comb begin
    w_state_nxt = r_state;
    w_cause_evt = 1'b0;
    w_cause_val = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (uart_rx_irq && (uart_rx_byte == PREAMBLE_BYTE) && r_en) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (uart_rx_irq) begin
          if (uart_rx_byte == TRIGGER_BYTE) begin
            w_state_nxt = S_FIRE;
            w_cause_evt = 1'b1;
            w_cause_val = CAUSE_TRIGGER;
          end else if ((uart_rx_byte == FILLER_BYTE) ||
                       (uart_rx_byte == PREAMBLE_BYTE)) begin
            w_state_nxt = S_ARMED;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FIRE: begin
        if (w_pulse_last) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (uart_rx_irq) begin
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (!uart_rx_irq && (r_timer == TIMER_LAST)) begin
          w_state_nxt = S_DONE;
          w_cause_evt = 1'b1;
          w_cause_val = CAUSE_DONE;
        end
      end
      S_DONE: begin
        if (w_pulse_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
`ifdef LOADER_SW_RESET_EN
    // A software reset outranks a byte that arrives in the same cycle
    if (w_sw_rst) begin
      w_state_nxt = S_DONE;
      w_cause_evt = 1'b1;
      w_cause_val = CAUSE_SWRST;
    end
`endif
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pulse width counter, restarted on every state entry
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_pulse_cnt <= 32'd0;
    end else if (w_state_nxt != r_state) begin
      r_pulse_cnt <= 32'd0;
    end else if ((r_state == S_FIRE) || (r_state == S_DONE)) begin
      r_pulse_cnt <= r_pulse_cnt + 32'd1;
    end
  end

  // Program byte counter: cleared when firing, saturating while receiving
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_byte_cnt <= 24'd0;
    end else if ((r_state != S_FIRE) && (w_state_nxt == S_FIRE)) begin
      r_byte_cnt <= 24'd0;
    end else if ((r_state == S_LOAD) && uart_rx_irq) begin
      r_byte_cnt <= 24'd1;
    end else if ((r_state == S_RECV) && uart_rx_irq && (r_byte_cnt != COUNT_MAX)) begin
      r_byte_cnt <= r_byte_cnt + 24'd1;
    end
  end

  // Inter-byte idle timer, restarted by every received byte during a load
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_timer <= 32'd0;
    end else if (((r_state == S_LOAD) || (r_state == S_RECV)) && uart_rx_irq) begin
      r_timer <= 32'd0;
    end else if (r_state == S_RECV) begin
      r_timer <= r_timer + 32'd1;
    end
  end

  // Registered core reset: low exactly while the FSM sits in a pulse state
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_reset_n <= 1'b1;
    end else begin
      r_reset_n <= !((w_state_nxt == S_FIRE) || (w_state_nxt == S_DONE));
    end
  end

  // Reset cause: a cause event outranks a firmware clear in the same cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cause <= 2'd0;
    end else if (w_cause_evt) begin
      r_cause <= w_cause_val;
    end else if (w_wr_cause) begin
      r_cause <= 2'd0;
    end
  end

  // Enable bit: gates only the IDLE to ARMED step
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_en <= 1'b1;
    end else if (w_wr_ctrl) begin
      r_en <= wb_dat_i[0];
    end
  end

  // Read data selection for the mapped registers
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_addr)
      ADR_CAUSE:  w_rd_mux = {30'd0, r_cause};
      ADR_STATUS: w_rd_mux = {r_byte_cnt, 5'd0, r_state};
      ADR_CTRL:   w_rd_mux = {31'd0, r_en};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  // Single-cycle bus response: ack for mapped words, err for the unmapped one
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_bus_req & (w_addr != ADR_NONE);
      r_err <= w_bus_req & (w_addr == ADR_NONE);
      r_dat <= w_rd ? w_rd_mux : 32'd0;
    end
  end

  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_dat_o   = r_dat;
  assign reset_o    = r_reset_n;
  assign state_o    = r_state;

endmodule

// File: tb/tb_loader_ctrl_wb.sv
// tb_loader_ctrl_wb: directed bench for loader_ctrl_wb with a short pulse and timeout.
// Expected results are hand-computed for RST_PULSE_CYCLES=4 and TIMEOUT_CYCLES=100.
// The software-reset expectations follow LOADER_SW_RESET_EN.

module tb_loader_ctrl_wb;

  localparam logic [31:0] A_CAUSE  = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_NONE   = 32'hC;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] datI = 32'd0;
  logic [3:0]  sel = 4'hF;
  logic        stallO;
  logic        ackO;
  logic        errO;
  logic [31:0] datO;
  logic        irq = 1'b0;
  logic [7:0]  rxByte = 8'd0;
  logic        resetO;
  logic [2:0]  stateO;

  int errors = 0;
  int checks = 0;
  int lowCount = 0;
  int base;
  logic [31:0] rd;
  logic        ack;
  logic        err;
  logic [31:0] expPulse;
  logic [31:0] expCause;
  logic [31:0] expState;

  loader_ctrl_wb #(
    .RST_PULSE_CYCLES(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rstN),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_we_i(we),
    .wb_adr_i(adr),
    .wb_dat_i(datI),
    .wb_sel_i(sel),
    .wb_stall_o(stallO),
    .wb_ack_o(ackO),
    .wb_err_o(errO),
    .wb_dat_o(datO),
    .uart_rx_irq(irq),
    .uart_rx_byte(rxByte),
    .reset_o(resetO),
    .state_o(stateO)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Count core-reset low cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (resetO === 1'b0) lowCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One received UART byte, sampled on the next rising edge
  task automatic applyStimulus(input logic [7:0] b);
    irq = 1'b1;
    rxByte = b;
    @(posedge clk);
    #1;
    irq = 1'b0;
    rxByte = 8'd0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d,
                         output logic k, output logic e);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    d = datO; k = ackO; e = errO;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d,
                          output logic k, output logic e);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; datI = d;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = 32'd0;
    k = ackO; e = errO;
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // Reset state
    #23 rstN = 1'b1;
    tick(1);
    checkOutput("rst_reset_o", 32'(resetO), 32'd1);
    checkOutput("rst_state", 32'(stateO), 32'd0);
    checkOutput("rst_stall", 32'(stallO), 32'd0);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("rst_cause", rd, 32'd0);
    checkOutput("rst_cause_ack", 32'(ack), 32'd1);
    busRead(A_CTRL, rd, ack, err);
    checkOutput("rst_ctrl", rd, 32'd1);
    busRead(A_STATUS, rd, ack, err);
    checkOutput("rst_status", rd, 32'd0);
    busRead(A_NONE, rd, ack, err);
    checkOutput("unmapped_rd_err", 32'(err), 32'd1);
    checkOutput("unmapped_rd_ack", 32'(ack), 32'd0);
    busWrite(A_NONE, 32'd0, ack, err);
    checkOutput("unmapped_wr_err", 32'(err), 32'd1);
    busRead(A_CTRL, rd, ack, err);
    checkOutput("unmapped_wr_noeffect", rd, 32'd1);
    busWrite(A_STATUS, 32'hFFFFFFFF, ack, err);
    checkOutput("status_wr_ack", 32'(ack), 32'd1);
    busRead(A_STATUS, rd, ack, err);
    checkOutput("status_wr_ignored", rd, 32'd0);

    // Arm sequence with filler and repeated preamble, then trigger
    applyStimulus(8'h2D);
    checkOutput("arm_state", 32'(stateO), 32'd1);
    applyStimulus(8'h5F);
    applyStimulus(8'h2D);
    checkOutput("armed_hold", 32'(stateO), 32'd1);
    checkOutput("pre_fire_rst", 32'(resetO), 32'd1);
    base = lowCount;
    applyStimulus(8'h70);
    checkOutput("fire_first_low", 32'(resetO), 32'd0);
    checkOutput("fire_state", 32'(stateO), 32'd2);
    tick(3);
    checkOutput("fire_last_low", 32'(resetO), 32'd0);
    tick(1);
    checkOutput("fire_end_high", 32'(resetO), 32'd1);
    checkOutput("fire_width", 32'(lowCount - base), 32'd4);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("cause_trigger", rd, 32'd1);
    checkOutput("load_state", 32'(stateO), 32'd3);

    // Ten spaced bytes, then silence until the timeout
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h10 + 8'(i));
      if (i < 9) tick(49);
    end
    base = lowCount;
    busRead(A_STATUS, rd, ack, err);
    checkOutput("recv_status", rd, 32'h00000A04);
    tick(98);
    checkOutput("pre_timeout_state", 32'(stateO), 32'd4);
    checkOutput("pre_timeout_rst", 32'(resetO), 32'd1);
    tick(1);
    checkOutput("timeout_state", 32'(stateO), 32'd5);
    checkOutput("timeout_low", 32'(resetO), 32'd0);
    tick(4);
    checkOutput("done_idle", 32'(stateO), 32'd0);
    checkOutput("done_width", 32'(lowCount - base), 32'd4);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("cause_done", rd, 32'd2);

    // Byte arriving on the terminal timer cycle keeps the load alive
    applyStimulus(8'h2D);
    applyStimulus(8'h70);
    tick(4);
    checkOutput("reload_state", 32'(stateO), 32'd3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h20 + 8'(i));
      if (i < 9) tick(49);
    end
    tick(99);
    checkOutput("terminal_pre", 32'(stateO), 32'd4);
    applyStimulus(8'hAA);
    checkOutput("terminal_irq_state", 32'(stateO), 32'd4);
    checkOutput("terminal_irq_rst", 32'(resetO), 32'd1);
    busRead(A_STATUS, rd, ack, err);
    checkOutput("terminal_count", rd, 32'h00000B04);
    tick(110);
    checkOutput("terminal_done_idle", 32'(stateO), 32'd0);
    busRead(A_STATUS, rd, ack, err);
    checkOutput("count_retained", rd, 32'h00000B00);

    // Wrong byte while armed, disabled arming, cause clear
    base = lowCount;
    applyStimulus(8'h2D);
    checkOutput("rearm_state", 32'(stateO), 32'd1);
    applyStimulus(8'h41);
    checkOutput("disarm_state", 32'(stateO), 32'd0);
    tick(5);
    checkOutput("disarm_nopulse", 32'(lowCount - base), 32'd0);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("disarm_cause", rd, 32'd2);
    busWrite(A_CTRL, 32'd0, ack, err);
    busRead(A_CTRL, rd, ack, err);
    checkOutput("ctrl_cleared", rd, 32'd0);
    base = lowCount;
    applyStimulus(8'h2D);
    checkOutput("disabled_pre", 32'(stateO), 32'd0);
    applyStimulus(8'h70);
    tick(5);
    checkOutput("disabled_state", 32'(stateO), 32'd0);
    checkOutput("disabled_nopulse", 32'(lowCount - base), 32'd0);
    busWrite(A_CAUSE, 32'hFFFFFFFF, ack, err);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("cause_clear", rd, 32'd0);
    busWrite(A_CTRL, 32'd1, ack, err);

    // Asynchronous reset in the middle of the trigger pulse
    applyStimulus(8'h2D);
    applyStimulus(8'h70);
    checkOutput("mid_fire_low", 32'(resetO), 32'd0);
    tick(1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async_rst_high", 32'(resetO), 32'd1);
    checkOutput("async_rst_state", 32'(stateO), 32'd0);
    #2 rstN = 1'b1;
    tick(1);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("async_rst_cause", rd, 32'd0);
    busRead(A_CTRL, rd, ack, err);
    checkOutput("async_rst_ctrl", rd, 32'd1);

    // Software reset request from IDLE
`ifdef LOADER_SW_RESET_EN
    expPulse = 32'd4;
    expCause = 32'd3;
    expState = 32'd5;
`else
    expPulse = 32'd0;
    expCause = 32'd0;
    expState = 32'd0;
`endif
    base = lowCount;
    busWrite(A_CTRL, 32'd3, ack, err);
    checkOutput("swrst_ack", 32'(ack), 32'd1);
    checkOutput("swrst_state", 32'(stateO), expState);
    tick(6);
    checkOutput("swrst_width", 32'(lowCount - base), expPulse);
    checkOutput("swrst_idle", 32'(stateO), 32'd0);
    busRead(A_CAUSE, rd, ack, err);
    checkOutput("swrst_cause", rd, expCause);
    busRead(A_CTRL, rd, ack, err);
    checkOutput("swrst_ctrl", rd, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
